// File: rtl/pulse_cdc_pkg.sv
// ==========================================================================
// pulse_cdc_pkg : FSM state encoding and default timing for pulse_cdc_arbiter
// Rev 1.0
// ==========================================================================
`default_nettype none

package pulse_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int DEFAULT_PULSE_W     = 3;
  localparam int DEFAULT_ACK_TIMEOUT = 16;
  localparam int DEFAULT_GAP_CYC     = 2;

endpackage

`default_nettype wire

// File: rtl/pulse_cdc_arbiter_rr_pick.sv
// ==========================================================================
// rr_pick : combinational round-robin picker, first set bit at or above rr_ptr
// Rev 1.0
// ==========================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!valid && pending[j]) begin
        winner = ID_W'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pulse_cdc_arbiter.sv
// ==========================================================================
// pulse_cdc_arbiter : round-robin scheduler sharing one pulse CDC channel.
// Rev 1.0   Optional: PCA_MERGE_CNT_EN adds the merge_cnt output.
// ==========================================================================
`default_nettype none

module pulse_cdc_arbiter
  import pulse_cdc_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int PULSE_W     = DEFAULT_PULSE_W,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter int GAP_CYC     = DEFAULT_GAP_CYC
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               ack_in,
  output logic               pulse_out,
  output logic [ID_W-1:0]    id_out,
  output logic [NUM_REQ-1:0] done,
  output logic               timeout_err,
  output logic               busy
`ifdef PCA_MERGE_CNT_EN
  ,
  output logic [7:0]         merge_cnt
`endif
);

  localparam int CNT_MAX = (PULSE_W > GAP_CYC) ? PULSE_W : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TCNT_W  = $clog2(ACK_TIMEOUT);

  state_t             state;
  logic [NUM_REQ-1:0] pending;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [TCNT_W-1:0]  tcnt;

  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic               grant;
  logic [NUM_REQ-1:0] grant_mask;
  logic [ID_W-1:0]    rr_next;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .winner  (pick_id),
    .valid   (pick_valid)
  );

  assign grant      = (state == IDLE) && pick_valid;
  assign grant_mask = grant ? (NUM_REQ'(1) << pick_id) : '0;
  assign rr_next    = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      pending     <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      pulse_out   <= 1'b0;
      id_out      <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      // A request arriving on its own grant edge survives the clear
      pending     <= (pending & ~grant_mask) | req;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            id_out    <= pick_id;
            pulse_out <= 1'b1;
            cnt       <= CNT_W'(PULSE_W - 1);
            rr_ptr    <= rr_next;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            pulse_out <= 1'b0;
            tcnt      <= '0;
            state     <= WAIT_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_in) begin
            done[id_out] <= 1'b1;
            cnt          <= CNT_W'(GAP_CYC - 1);
            state        <= GAP;
          end else if (tcnt == TCNT_W'(ACK_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            cnt         <= CNT_W'(GAP_CYC - 1);
            state       <= GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PCA_MERGE_CNT_EN
  logic [NUM_REQ-1:0] active_mask;
  logic               merge_hit;

  assign active_mask = ((state == DRIVE) || (state == WAIT_ACK)) ?
                       (NUM_REQ'(1) << id_out) : '0;
  assign merge_hit   = |(req & (pending | active_mask));

  always_ff @(posedge clk) begin
    if (!rstn)                              merge_cnt <= '0;
    else if (merge_hit && merge_cnt != 8'hFF) merge_cnt <= merge_cnt + 8'd1;
  end
`else
  // Merged requests simply collapse into the pending OR above.
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_cdc_arbiter.sv
// ==========================================================================
// tb_pulse_cdc_arbiter : directed self-checking bench for pulse_cdc_arbiter
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_pulse_cdc_arbiter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] req = '0;
  logic       ack_in = 1'b0;
  logic       pulse_out;
  logic [1:0] id_out;
  logic [3:0] done;
  logic       timeout_err;
  logic       busy;
`ifdef PCA_MERGE_CNT_EN
  logic [7:0] merge_cnt;
`endif

  int total = 0;
  int bad   = 0;

  int done_seen [4] = '{0, 0, 0, 0};
  int to_seen       = 0;
  int pulse_cyc     = 0;

  pulse_cdc_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .ack_in      (ack_in),
    .pulse_out   (pulse_out),
    .id_out      (id_out),
    .done        (done),
    .timeout_err (timeout_err),
    .busy        (busy)
`ifdef PCA_MERGE_CNT_EN
    ,
    .merge_cnt   (merge_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (done[i]) done_seen[i]++;
    if (timeout_err) to_seen++;
    if (pulse_out) pulse_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn   = 1'b0;
    req    = '0;
    ack_in = 1'b0;
    step(2);
    rstn   = 1'b1;
  endtask

  task automatic wait_rise(input string tag, output int n);
    n = 0;
    while (!pulse_out && n < 60) begin
      step();
      n++;
    end
    check({tag, "_rise"}, 32'(pulse_out), 32'd1);
  endtask

  // From the rise cycle: check id and width, ack on first WAIT_ACK cycle, check done
  task automatic finish(input logic [1:0] exp_id, input string tag);
    int n;
    check({tag, "_id"}, 32'(id_out), 32'(exp_id));
    n = 0;
    while (pulse_out && n < 20) begin
      step();
      n++;
    end
    check({tag, "_width"}, 32'(n), 32'd3);
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    check({tag, "_done"}, 32'(done), 32'(4'b0001 << exp_id));
  endtask

  task automatic serve(input logic [1:0] exp_id, input string tag);
    int n;
    wait_rise(tag, n);
    finish(exp_id, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int n;
    int base [4];
    int base_to;
    int base_p;

    // ---------------- reset state and single-request latency
    do_reset();
    rstn = 1'b0;
    step();
    check("rst_pulse", 32'(pulse_out), 32'd0);
    check("rst_id", 32'(id_out), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_to", 32'(timeout_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    req  = 4'b0001;               // cycle 0
    step();  req = '0;            // cycle 1
    check("t1_c1_pulse", 32'(pulse_out), 32'd0);
    check("t1_c1_busy", 32'(busy), 32'd0);
    step();                       // cycle 2
    check("t1_c2_pulse", 32'(pulse_out), 32'd1);
    check("t1_c2_id", 32'(id_out), 32'd0);
    check("t1_c2_busy", 32'(busy), 32'd1);
    step();  check("t1_c3_pulse", 32'(pulse_out), 32'd1);
    step();  check("t1_c4_pulse", 32'(pulse_out), 32'd1);
    step();  check("t1_c5_pulse", 32'(pulse_out), 32'd0);
    step();  ack_in = 1'b1;       // cycle 6
    check("t1_c6_done", 32'(done), 32'd0);
    step();  ack_in = 1'b0;       // cycle 7
    check("t1_c7_done", 32'(done), 32'b0001);
    step();                       // cycle 8
    check("t1_c8_done", 32'(done), 32'd0);
    check("t1_c8_busy", 32'(busy), 32'd1);
    step();                       // cycle 9
    check("t1_c9_busy", 32'(busy), 32'd0);

    // ---------------- all four requesters, round-robin order
    do_reset();
    for (int i = 0; i < 4; i++) base[i] = done_seen[i];
    req = 4'b1111;
    step();  req = '0;
    serve(2'd0, "rr0");
    serve(2'd1, "rr1");
    serve(2'd2, "rr2");
    serve(2'd3, "rr3");
    step(4);
    check("rr_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_done_cnt%0d", i), 32'(done_seen[i] - base[i]), 32'd1);

    // ---------------- acknowledge timeout
    do_reset();
    base[2] = done_seen[2];
    base_to = to_seen;
    req = 4'b0100;
    step();  req = '0;
    wait_rise("to", n);
    check("to_id", 32'(id_out), 32'd2);
    n = 0;
    while (pulse_out && n < 20) begin step(); n++; end
    n = 0;
    while (!timeout_err && n < 40) begin step(); n++; end
    check("to_cycles", 32'(n), 32'd16);
    check("to_done", 32'(done), 32'd0);
    req = 4'b0001;
    step();  req = '0;
    check("to_gap_busy", 32'(busy), 32'd1);
    wait_rise("to_next", n);
    check("to_next_lat", 32'(n), 32'd2);
    finish(2'd0, "to_next");
    step(4);
    check("to_done_cnt", 32'(done_seen[2] - base[2]), 32'd0);
    check("to_err_cnt", 32'(to_seen - base_to), 32'd1);

    // ---------------- stray acknowledges in IDLE, DRIVE and GAP
    do_reset();
    base_to = to_seen;
    ack_in = 1'b1;
    step();  ack_in = 1'b0;
    check("stray_idle_busy", 32'(busy), 32'd0);
    check("stray_idle_done", 32'(done), 32'd0);
    req = 4'b1000;
    step();  req = '0;
    wait_rise("stray", n);
    check("stray_id", 32'(id_out), 32'd3);
    ack_in = 1'b1;
    step();  ack_in = 1'b0;
    check("stray_drive_pulse", 32'(pulse_out), 32'd1);
    check("stray_drive_done", 32'(done), 32'd0);
    step();  check("stray_drive_pulse2", 32'(pulse_out), 32'd1);
    step();  check("stray_wait_pulse", 32'(pulse_out), 32'd0);
    ack_in = 1'b1;
    step();  ack_in = 1'b0;
    check("stray_real_done", 32'(done), 32'b1000);
    step();  ack_in = 1'b1;
    check("stray_gap_busy", 32'(busy), 32'd1);
    step();  ack_in = 1'b0;
    check("stray_gap_end_busy", 32'(busy), 32'd0);
    check("stray_gap_done", 32'(done), 32'd0);
    step(2);
    check("stray_to_cnt", 32'(to_seen - base_to), 32'd0);

    // ---------------- reset during DRIVE drops pending 1010
    do_reset();
    req = 4'b0001;
    step();  req = 4'b1010;
    step();  req = '0;
    check("mid_pulse_before", 32'(pulse_out), 32'd1);
    rstn = 1'b0;
    step();
    check("mid_pulse_after", 32'(pulse_out), 32'd0);
    check("mid_busy_after", 32'(busy), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) base[i] = done_seen[i];
    base_p = pulse_cyc;
    step(30);
    check("mid_no_pulse", 32'(pulse_cyc - base_p), 32'd0);
    check("mid_no_done", 32'((done_seen[0] - base[0]) + (done_seen[1] - base[1]) +
                             (done_seen[2] - base[2]) + (done_seen[3] - base[3])), 32'd0);
    check("mid_idle", 32'(busy), 32'd0);

`ifdef PCA_MERGE_CNT_EN
    // ---------------- merge counter
    do_reset();
    check("mg_rst", 32'(merge_cnt), 32'd0);
    base[1] = done_seen[1];
    req = 4'b0001;                // cycle 0
    step();  req = '0;            // cycle 1
    step();  req = 4'b0010;       // cycle 2: id 0 active, pending[1] clear
    step(3);                      // cycles 3..5: pending[1] set, three merges
    ack_in = 1'b1;
    step();  req = '0;  ack_in = 1'b0;
    check("mg_done0", 32'(done), 32'b0001);
    serve(2'd1, "mg1");
    step(4);
    check("mg_cnt3", 32'(merge_cnt), 32'd3);
    check("mg_done1_cnt", 32'(done_seen[1] - base[1]), 32'd1);
    req = 4'b0010;
    step(300);
    req = '0;
    step(3);
    check("mg_sat", 32'(merge_cnt), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
